// File: rtl/core_run_controller_if.sv
// Program-load stream into the run controller: valid/ready handshake carrying
// one 32-bit instruction word per transfer.
interface core_run_controller_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;

  modport master (output ld_valid, output ld_data, input  ld_ready);
  modport slave  (input  ld_valid, input  ld_data, output ld_ready);
endinterface

// File: rtl/core_run_controller.sv
// Load/run/halt sequencer for the single-cycle core: streams a program into
// imem, releases core reset, and stops on halt store, cycle limit or abort.
module core_run_controller #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          ADDR_W     = 6,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] HALT_ADDR  = 32'h0000_00FC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W:0]       load_count,
  input  logic [CNT_W-1:0]      cycle_limit,
  core_run_controller_if.slave  ld,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  input  logic                  memwrite,
  input  logic [31:0]           dataadr,
  input  logic [31:0]           writedata,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            halt_cause,
  output logic [31:0]           exit_code,
  output logic [CNT_W-1:0]      cycles_run
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);

  state_t            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CNT_W-1:0]  cycles_q;
  logic [1:0]        cause_q;
  logic [31:0]       exit_q;

  logic [ADDR_W:0]   count_d;
  logic              xfer;
  logic              halt_st;

  always_comb begin
    count_d = (load_count > DEPTH_C) ? DEPTH_C : load_count;
  end

  // ld_ready drops during abort so the abort cycle can never write imem.
  assign ld.ld_ready = (state_q == LOAD) && !abort;
  assign xfer        = ld.ld_valid && ld.ld_ready;
  assign imem_we     = xfer;
  assign imem_waddr  = wcnt_q[ADDR_W-1:0];
  assign imem_wdata  = xfer ? ld.ld_data : '0;
  assign halt_st     = memwrite && (dataadr == HALT_ADDR);

  assign core_reset  = (state_q != RUN);
  assign busy        = (state_q == LOAD) || (state_q == RELEASE) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign halt_cause  = cause_q;
  assign exit_code   = exit_q;
  assign cycles_run  = cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wcnt_q   <= '0;
      limit_q  <= '0;
      cycles_q <= '0;
      cause_q  <= 2'd0;
      exit_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            count_q  <= count_d;
            limit_q  <= cycle_limit;
            wcnt_q   <= '0;
            cycles_q <= '0;
            cause_q  <= 2'd0;
            exit_q   <= '0;
            state_q  <= (count_d == '0) ? RELEASE : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            cause_q <= 2'd3;
            state_q <= DONE;
          end else if (xfer) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == count_q - 1'b1) state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (abort) begin
            cause_q <= 2'd3;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          if (abort) begin
            cause_q <= 2'd3;
            state_q <= DONE;
          end else if (halt_st) begin
            exit_q  <= writedata;
            cause_q <= 2'd1;
            state_q <= DONE;
          end else if ((limit_q != '0) && (cycles_q + 1'b1 == limit_q)) begin
            cause_q <= 2'd2;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
